// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: reset vector, trap/redirect override,
// valid/ready fetch handshake with a one-cycle flush bubble, and a circular return-address stack.
module pc_gen #(
  parameter int                XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
  parameter int                ILEN_BYTES   = 4,
  parameter int                RAS_DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         trap_valid,
  input  logic [XLEN-1:0]              trap_vector,
  input  logic                         redirect_valid,
  input  logic [XLEN-1:0]              redirect_pc,
  input  logic                         call_push,
  input  logic                         ret_pop,
  input  logic                         fetch_ready,
  output logic                         fetch_valid,
  output logic [XLEN-1:0]              pc_out,
  output logic                         misaligned,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(ILEN_BYTES - 1);
  localparam logic [XLEN-1:0] INC      = XLEN'(ILEN_BYTES);
  localparam logic [CW-1:0]   FULL     = CW'(RAS_DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic                mis_q, mis_d;
  logic [XLEN-1:0]     ras_mem [RAS_DEPTH];
  logic [PW-1:0]       ptr_q;
  logic [CW-1:0]       cnt_q;
  logic                ovf_q;

  logic                advance;
  logic                do_push, do_pop, do_swap, do_clear;
  logic [PW-1:0]       top_idx;
  logic [XLEN-1:0]     ret_addr;

  // ptr_q is the next free slot, so the top of stack is one below it (mod depth).
  assign top_idx  = ptr_q - 1'b1;
  assign ret_addr = pc_q + INC;
  assign advance  = (state_q == RUN) && fetch_ready && !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    mis_d    = 1'b0;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    do_swap  = 1'b0;
    do_clear = 1'b0;
    if (trap_valid) begin
      pc_d     = trap_vector & ~LOW_MASK;
      mis_d    = |(trap_vector & LOW_MASK);
      do_clear = 1'b1;
      state_d  = FLUSH;
    end else if (redirect_valid) begin
      pc_d    = redirect_pc & ~LOW_MASK;
      mis_d   = |(redirect_pc & LOW_MASK);
      state_d = FLUSH;
    end else if (!advance) begin
      if (state_q != RUN) state_d = RUN;
    end else if (ret_pop && cnt_q != '0) begin
      // A call+return pair replaces the top entry in place instead of pop-then-push.
      pc_d    = ras_mem[top_idx];
      do_swap = call_push;
      do_pop  = !call_push;
    end else begin
      pc_d    = pc_q + INC;
      do_push = call_push;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (do_clear) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (do_push) begin
      // When full, ptr_q already points at the oldest entry, so it is the one overwritten.
      ptr_q <= ptr_q + 1'b1;
      if (cnt_q == FULL) ovf_q <= 1'b1;
      else               cnt_q <= cnt_q + 1'b1;
    end else if (do_pop) begin
      ptr_q <= top_idx;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !do_clear) begin
      if (do_push)      ras_mem[ptr_q]   <= ret_addr;
      else if (do_swap) ras_mem[top_idx] <= ret_addr;
    end
  end

  assign fetch_valid  = (state_q == RUN);
  assign pc_out       = pc_q;
  assign misaligned   = mis_q;
  assign ras_count    = cnt_q;
  assign ras_overflow = ovf_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a queue-based reference model checked every cycle,
// plus literal expectations at the points the test plan names.
module tb_pc_gen;
  localparam logic [31:0] RV = 32'h1000;

  logic        clk = 1'b0;
  logic        rst, stall, trap_valid, redirect_valid, call_push, ret_pop, fetch_ready;
  logic [31:0] trap_vector, redirect_pc;
  logic        fetch_valid, misaligned, ras_overflow;
  logic [31:0] pc_out;
  logic [2:0]  ras_count;

  int total = 0;
  int bad   = 0;

  pc_gen #(.XLEN(32), .RESET_VECTOR(RV), .ILEN_BYTES(4), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .trap_valid(trap_valid), .trap_vector(trap_vector),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .call_push(call_push), .ret_pop(ret_pop), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .pc_out(pc_out), .misaligned(misaligned),
    .ras_count(ras_count), .ras_overflow(ras_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain stack with drop-oldest on overflow; "valid" is simply
  // "not in reset and no redirect in the previous cycle and not the first cycle after one".
  logic [31:0] m_pc;
  logic        m_valid, m_mis, m_ovf;
  logic [31:0] ras[$];
  bit          started = 0;

  always @(posedge clk) begin
    logic adv;
    logic [31:0] ra;
    if (rst) begin
      m_pc = RV; m_valid = 0; m_mis = 0; m_ovf = 0; ras.delete();
    end else begin
      adv = m_valid && fetch_ready && !stall;
      ra  = m_pc + 32'd4;
      m_mis = 0;
      if (trap_valid) begin
        m_pc = {trap_vector[31:2], 2'b00}; m_mis = (trap_vector[1:0] != 0);
        ras.delete(); m_valid = 0;
      end else if (redirect_valid) begin
        m_pc = {redirect_pc[31:2], 2'b00}; m_mis = (redirect_pc[1:0] != 0);
        m_valid = 0;
      end else if (!adv) begin
        m_valid = 1;
      end else if (ret_pop && ras.size() > 0) begin
        m_pc = ras.pop_back();
        if (call_push) ras.push_back(ra);
      end else begin
        m_pc = ra;
        if (call_push) begin
          if (ras.size() == 4) begin void'(ras.pop_front()); m_ovf = 1; end
          ras.push_back(ra);
        end
      end
    end
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_fetch_valid", 64'(fetch_valid), 64'(m_valid));
      chk("model_pc", 64'(pc_out), 64'(m_pc));
      chk("model_misaligned", 64'(misaligned), 64'(m_mis));
      chk("model_ras_count", 64'(ras_count), 64'(ras.size()));
      chk("model_ras_overflow", 64'(ras_overflow), 64'(m_ovf));
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic redirect_to(input logic [31:0] tgt);
    redirect_valid = 1; redirect_pc = tgt;
    step();
    redirect_valid = 0;
    step();
  endtask

  initial begin
    rst = 1; stall = 0; trap_valid = 0; redirect_valid = 0; call_push = 0; ret_pop = 0;
    fetch_ready = 0; trap_vector = 0; redirect_pc = 0;
    step(2);
    chk("reset_pc", 64'(pc_out), 64'h1000);
    chk("reset_valid", 64'(fetch_valid), 64'd0);
    chk("reset_count", 64'(ras_count), 64'd0);

    rst = 0; fetch_ready = 1;
    step();
    chk("boot_to_run_valid", 64'(fetch_valid), 64'd1);
    chk("boot_pc", 64'(pc_out), 64'h1000);
    step(); chk("seq_1004", 64'(pc_out), 64'h1004);
    step(); chk("seq_1008", 64'(pc_out), 64'h1008);
    step(); chk("seq_100c", 64'(pc_out), 64'h100C);

    stall = 1; step(2);
    chk("stall_hold", 64'(pc_out), 64'h100C);
    stall = 0; fetch_ready = 0; step(2);
    chk("notready_hold", 64'(pc_out), 64'h100C);
    fetch_ready = 1; step();
    chk("resume_1010", 64'(pc_out), 64'h1010);

    call_push = 1; step(); call_push = 0;
    chk("push_count1", 64'(ras_count), 64'd1);
    trap_valid = 1; trap_vector = 32'h80; redirect_valid = 1; redirect_pc = 32'h200; stall = 1;
    step();
    chk("trap_wins_pc", 64'(pc_out), 64'h80);
    chk("trap_bubble", 64'(fetch_valid), 64'd0);
    chk("trap_clears_ras", 64'(ras_count), 64'd0);
    trap_valid = 0; redirect_valid = 0; stall = 0;
    step(); chk("trap_refill", 64'(fetch_valid), 64'd1);
    step(); chk("trap_adv", 64'(pc_out), 64'h84);

    redirect_valid = 1; redirect_pc = 32'h203; step(); redirect_valid = 0;
    chk("misalign_pc", 64'(pc_out), 64'h200);
    chk("misalign_pulse", 64'(misaligned), 64'd1);
    step();
    chk("misalign_clear", 64'(misaligned), 64'd0);

    redirect_to(32'h100);
    call_push = 1; step(); call_push = 0;
    chk("call_pc", 64'(pc_out), 64'h104);
    redirect_to(32'h400);
    ret_pop = 1; step(); ret_pop = 0;
    chk("ret_pc", 64'(pc_out), 64'h104);
    chk("ret_count0", 64'(ras_count), 64'd0);
    redirect_to(32'h10);
    ret_pop = 1; step(); ret_pop = 0;
    chk("ret_empty_seq", 64'(pc_out), 64'h14);

    redirect_to(32'h2000);
    call_push = 1; step(5); call_push = 0;
    chk("ovf_count", 64'(ras_count), 64'd4);
    chk("ovf_flag", 64'(ras_overflow), 64'd1);
    ret_pop = 1;
    step(); chk("pop_a5", 64'(pc_out), 64'h2014);
    step(); chk("pop_a4", 64'(pc_out), 64'h2010);
    step(); chk("pop_a3", 64'(pc_out), 64'h200C);
    step(); chk("pop_a2", 64'(pc_out), 64'h2008);
    step(); chk("pop_empty_seq", 64'(pc_out), 64'h200C);
    call_push = 1; step();
    chk("pushpop_empty_pc", 64'(pc_out), 64'h2010);
    step();
    chk("pushpop_swap_pc", 64'(pc_out), 64'h2010);
    chk("pushpop_swap_cnt", 64'(ras_count), 64'd1);
    call_push = 0; step(); ret_pop = 0;
    chk("swap_top_value", 64'(pc_out), 64'h2014);

    redirect_valid = 1; redirect_pc = 32'h500; step();
    redirect_pc = 32'h600; step(); redirect_valid = 0;
    chk("b2b_bubble", 64'(fetch_valid), 64'd0);
    chk("b2b_pc", 64'(pc_out), 64'h600);
    step();

    redirect_to(32'hFFFF_FFFC);
    step(); chk("wrap", 64'(pc_out), 64'h0);

    redirect_valid = 1; redirect_pc = 32'h300; step(); redirect_valid = 0;
    rst = 1; step();
    chk("rst_flush_pc", 64'(pc_out), 64'h1000);
    chk("rst_flush_valid", 64'(fetch_valid), 64'd0);
    chk("rst_flush_ovf", 64'(ras_overflow), 64'd0);
    rst = 0; step();
    chk("rst_rerun", 64'(fetch_valid), 64'd1);
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
